// File: rtl/shift_arbiter_pkg.sv
// Shared types and constants for the shift arbiter: vector geometry, default shift width, FSM states.
`ifndef MAX_NEURONS
`define MAX_NEURONS 4
`endif

package shift_arbiter_pkg;

    localparam int MAX_NEURONS = `MAX_NEURONS;
    localparam int ELEM_W      = 16;
    localparam int ARR_W       = MAX_NEURONS * ELEM_W;
    localparam int SHIFT_W_DEF = 5;

    typedef logic [MAX_NEURONS-1:0][ELEM_W-1:0] arr_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_HOLD
    } state_e;

endpackage

// File: rtl/shift_arbiter_scalar_shift.sv
// Element-wise logical right shift of a packed vector by one shared amount (zero-fill).
module scalar_shift
    import shift_arbiter_pkg::*;
#(
    parameter int EL_W    = ELEM_W,
    parameter int NUM_EL  = MAX_NEURONS,
    parameter int SHIFT_W = SHIFT_W_DEF
) (
    input  logic [NUM_EL*EL_W-1:0] vec_i,
    input  logic [SHIFT_W-1:0]     shamt_i,
    output logic [NUM_EL*EL_W-1:0] vec_o
);

    always_comb begin
        vec_o = '0;
        for (int k = 0; k < NUM_EL; k++) begin
            // Shift amounts at or beyond the element width flush the element to zero.
            if (int'(shamt_i) < EL_W) begin
                vec_o[k*EL_W +: EL_W] = vec_i[k*EL_W +: EL_W] >> shamt_i;
            end
        end
    end

endmodule

// File: rtl/shift_arbiter.sv
// Round-robin arbiter sharing one scalar_shift datapath between NUM_REQ requesters.
module shift_arbiter
    import shift_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ),
    parameter int SHIFT_W = SHIFT_W_DEF
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [NUM_REQ*ARR_W-1:0]   req_vector,
    input  logic [NUM_REQ*SHIFT_W-1:0] req_scalar,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [ARR_W-1:0]           out_vector,
    output logic [ID_W-1:0]            out_id,
    output logic                       busy
);

    state_e             state_q;
    logic [ID_W-1:0]    rr_ptr_q;
    logic [ARR_W-1:0]   vec_q;
    logic [SHIFT_W-1:0] sc_q;
    logic [ID_W-1:0]    id_q;
    logic               out_valid_q;
    logic [ARR_W-1:0]   out_vector_q;
    logic [ID_W-1:0]    out_id_q;

    logic [ID_W:0]      pick;
    logic               grant_en;
    logic [ID_W-1:0]    grant_idx;
    logic [ID_W-1:0]    rr_ptr_d;
    logic [ARR_W-1:0]   shift_res;

    // Scanning offsets from high to low lets the lowest offset from ptr overwrite the result last.
    function automatic logic [ID_W:0] rr_pick(input logic [NUM_REQ-1:0] v,
                                              input logic [ID_W-1:0]    ptr);
        logic [ID_W:0] res;
        int            idx;
        res = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = (int'(ptr) + k) % NUM_REQ;
            if (v[idx]) begin
                res = {1'b1, ID_W'(idx)};
            end
        end
        return res;
    endfunction

    always_comb begin
        pick      = rr_pick(req_valid, rr_ptr_q);
        grant_idx = pick[ID_W-1:0];
        grant_en  = pick[ID_W] && !rst &&
                    ((state_q == ST_IDLE) || ((state_q == ST_HOLD) && out_ready));
        rr_ptr_d  = ID_W'((int'(grant_idx) + 1) % NUM_REQ);
        req_ready = grant_en ? (NUM_REQ'(1) << grant_idx) : '0;
    end

    scalar_shift #(
        .EL_W    (ELEM_W),
        .NUM_EL  (MAX_NEURONS),
        .SHIFT_W (SHIFT_W)
    ) u_shift (
        .vec_i   (vec_q),
        .shamt_i (sc_q),
        .vec_o   (shift_res)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            rr_ptr_q     <= '0;
            vec_q        <= '0;
            sc_q         <= '0;
            id_q         <= '0;
            out_valid_q  <= 1'b0;
            out_vector_q <= '0;
            out_id_q     <= '0;
        end else begin
            if (grant_en) begin
                vec_q    <= req_vector[int'(grant_idx)*ARR_W +: ARR_W];
                sc_q     <= req_scalar[int'(grant_idx)*SHIFT_W +: SHIFT_W];
                id_q     <= grant_idx;
                rr_ptr_q <= rr_ptr_d;
            end
            case (state_q)
                ST_IDLE: begin
                    if (grant_en) state_q <= ST_SHIFT;
                end
                ST_SHIFT: begin
                    out_vector_q <= shift_res;
                    out_id_q     <= id_q;
                    out_valid_q  <= 1'b1;
                    state_q      <= ST_HOLD;
                end
                ST_HOLD: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= grant_en ? ST_SHIFT : ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign out_valid  = out_valid_q;
    assign out_vector = out_vector_q;
    assign out_id     = out_id_q;
    assign busy       = (state_q != ST_IDLE);

endmodule
